// File: rtl/tx_core_if.sv
// Host write port of the UART transmit core: byte, active-low write strobe and FIFO flags.
interface tx_core_if;
  logic [7:0] data_i;
  logic       n_we_i;
  logic       p_full_o;
  logic       p_empty_o;

  modport master (output data_i, n_we_i, input p_full_o, p_empty_o);
  modport slave  (input data_i, n_we_i, output p_full_o, p_empty_o);
endinterface

// File: rtl/tx_core.sv
// UART transmit core: byte FIFO feeding a baud-paced framer (start, 8 data, optional parity, 1-2 stop).
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (line low)
// DATA   | 8 data bits, bit_cnt selects the bit
// PARITY | parity bit
// STOP   | stop bit(s), stop_cnt tracks the second one
module tx_core #(
  parameter int DEPTH = 128
) (
  input  logic       clk,
  input  logic       rst,
  tx_core_if.slave   bus,
  input  logic       BaudSig_i,
  input  logic       p_ParityEnable_i,
  input  logic       ParityMethod_i,
  input  logic       p_BigEnd_i,
  input  logic       p_TwoStop_i,
  output logic       p_Busy_o,
  output logic       p_FrameDone_o,
  output logic [7:0] OverflowNum_o,
  output logic       Tx_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, wr_en, rd_en, last_stop;

  state_t        state;
  logic [7:0]    shift_byte;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic          par_en_l, par_odd_l, big_l, two_l;

  function automatic logic pick(input logic [7:0] b, input logic [2:0] idx, input logic big);
    return big ? b[3'd7 - idx] : b[idx];
  endfunction

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign bus.p_full_o  = full;
  assign bus.p_empty_o = empty;
  assign wr_en         = !bus.n_we_i && !full;
  assign last_stop     = (state == STOP) && (!two_l || stop_cnt);
  // The baud pulse that closes STOP also serves IDLE, so the next byte pops with no gap.
  assign rd_en         = BaudSig_i && !empty && ((state == IDLE) || last_stop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      OverflowNum_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      if (!bus.n_we_i && full && (OverflowNum_o != 8'hFF))
        OverflowNum_o <= OverflowNum_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      Tx_o          <= 1'b1;
      p_Busy_o      <= 1'b0;
      p_FrameDone_o <= 1'b0;
      shift_byte    <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      par_en_l      <= 1'b0;
      par_odd_l     <= 1'b0;
      big_l         <= 1'b0;
      two_l         <= 1'b0;
    end else begin
      p_FrameDone_o <= 1'b0;
      if (rd_en) begin
        shift_byte <= mem[rd_ptr];
        par_en_l   <= p_ParityEnable_i;
        par_odd_l  <= ParityMethod_i;
        big_l      <= p_BigEnd_i;
        two_l      <= p_TwoStop_i;
      end
      if (BaudSig_i) begin
        case (state)
          IDLE: begin
            if (!empty) begin
              state    <= START;
              Tx_o     <= 1'b0;
              p_Busy_o <= 1'b1;
            end
          end
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            Tx_o    <= pick(shift_byte, 3'd0, big_l);
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              if (par_en_l) begin
                state <= PARITY;
                Tx_o  <= (^shift_byte) ^ par_odd_l;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                Tx_o     <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              Tx_o    <= pick(shift_byte, bit_cnt + 3'd1, big_l);
            end
          end
          PARITY: begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            Tx_o     <= 1'b1;
          end
          STOP: begin
            if (!last_stop) begin
              stop_cnt <= 1'b1;
            end else begin
              p_FrameDone_o <= 1'b1;
              if (!empty) begin
                state <= START;
                Tx_o  <= 1'b0;
              end else begin
                state    <= IDLE;
                Tx_o     <= 1'b1;
                p_Busy_o <= 1'b0;
              end
            end
          end
          default: begin
            state    <= IDLE;
            Tx_o     <= 1'b1;
            p_Busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/tx_core.md
# tx_core

Serial transmit core for the UART: the transmit-side counterpart of the receive core. Bytes written by the host are buffered in an internal FIFO, then framed and shifted out on `Tx_o`. A frame is one start bit, 8 data bits (LSB- or MSB-first), an optional parity bit and one or two stop bits. Bit timing comes from the shared baud-rate generator through `BaudSig_i`.

## Interface

Parameters:
- `DEPTH`, default 128: FIFO depth in bytes. Must be a power of two, 2..256.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `data_i` in 8: byte to transmit.
- `n_we_i` in 1: FIFO write strobe, active low. One byte is written per cycle in which it is low.
- `p_full_o` out 1: FIFO full.
- `p_empty_o` out 1: FIFO empty.
- `BaudSig_i` in 1: one-cycle pulse, once per bit period.
- `p_ParityEnable_i` in 1: 1 = append a parity bit.
- `ParityMethod_i` in 1: 0 = even parity, 1 = odd parity.
- `p_BigEnd_i` in 1: 1 = MSB first, 0 = LSB first.
- `p_TwoStop_i` in 1: 1 = two stop bits, 0 = one stop bit.
- `p_Busy_o` out 1: high while a frame is in progress (any state other than IDLE).
- `p_FrameDone_o` out 1: one-cycle pulse when the last stop bit ends.
- `OverflowNum_o` out 8: count of dropped writes; saturates at 255.
- `Tx_o` out 1: serial line output, registered, idles high.

## Operation

Reset values: `Tx_o`=1, `p_Busy_o`=0, `p_FrameDone_o`=0, `OverflowNum_o`=0, `p_empty_o`=1, `p_full_o`=0, FIFO pointers 0, state IDLE.

FIFO:
- Write when `n_we_i`=0 and not full.
- A write while full is dropped and increments `OverflowNum_o`. This holds even if a read occurs in the same cycle.
- A read and a write in the same cycle are both honoured.
- Pointers wrap modulo `DEPTH`. Full and empty are derived from an occupancy count of width log2(`DEPTH`)+1.

State machine (advances only on cycles where `BaudSig_i`=1):
- IDLE: if the FIFO is not empty, pop one byte into the shift register and latch the parity, endianness and stop-bit configuration. Go to START. Otherwise stay in IDLE with `Tx_o`=1.
- START: `Tx_o`=0 for one bit period. Go to DATA with bit counter = 0.
- DATA: `Tx_o` = the current data bit (bit[counter] if LSB-first, bit[7-counter] if MSB-first). After counter 7, go to PARITY if parity is enabled, else STOP.
- PARITY: `Tx_o` = XOR of the 8 data bits, XOR `ParityMethod`. Go to STOP.
- STOP: `Tx_o`=1. Lasts one bit period, or two if two stop bits are latched (a stop counter selects which). On exit, pulse `p_FrameDone_o` and return to IDLE.
- Configuration inputs that change mid-frame have no effect until the next frame.

Back-to-back frames: the `BaudSig_i` that ends STOP is also evaluated in IDLE on the same cycle. If the FIFO is non-empty, the next START begins immediately, with no idle gap.

## Timing

- `Tx_o` changes on the clock edge following the sampled `BaudSig_i`. The first cycle of each bit is aligned to the baud pulse plus one clock.
- Write-to-line latency (FIFO empty, idle): the first `BaudSig_i` at least 1 cycle after the write starts the START bit; `Tx_o` falls 1 clock after that pulse.
- `p_empty_o` deasserts 1 cycle after the write edge. `p_full_o` is updated on the same edge as the pointers.
- Frame length in baud periods: 10, plus 1 with parity, plus 1 with two stop bits (range 10..12).
- `p_FrameDone_o` is high in the cycle following the last stop-bit baud pulse.
- Asserting `rst` mid-frame forces `Tx_o`=1 immediately (asynchronously) and clears FIFO contents and counters.

## Test plan

- Reset, then write 0x31; no parity, LSB-first, one stop bit -> `Tx_o` per baud period: 0,1,0,0,0,1,1,0,0,1. One `p_FrameDone_o` pulse. `p_empty_o`=1 afterwards.
- 0x31, MSB-first, even parity, two stop bits -> 0,0,0,1,1,0,0,0,1,1,1,1. Repeat with odd parity -> parity bit 0.
- Write 0x55 and 0xAA back-to-back -> 20 consecutive bit periods with no idle bit between frames. `p_Busy_o` stays high throughout.
- Fill the FIFO with `DEPTH` writes while `BaudSig_i` is held low -> `p_full_o`=1. Three more writes -> `OverflowNum_o`=3, and FIFO contents are unchanged (verify by draining).
- Assert `rst` in the middle of the DATA state -> `Tx_o`=1 with no clock edge required, FIFO empty, and no frame resumes after release.
- Toggle `p_BigEnd_i` and `p_ParityEnable_i` during a frame -> the current frame uses the latched values and the next frame uses the new ones.
